rtc_bus_ctrl: RTL and testbench
===============================

# rtc_bus_ctrl

Bus-sequencing engine between the PicoBlaze port register bank and the external V3023 real-time clock. On a write request it transfers the nine BCD time/timer bytes over the RTC's multiplexed address/data bus, then issues the commit command. On a read request it latches the RTC and reads the nine registers back into the `*le` bytes that the port bank returns to the processor. It raises `Listo_es`/`Listo_rd` when a sequence completes.

## Interface
- `T_PHASE`, default 10: clock cycles per bus phase, legal range 1..255 (100 ns at 100 MHz).
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low.
- `start_wr` in 1: request a write sequence; sampled only in IDLE.
- `start_rd` in 1: request a read sequence; sampled only in IDLE.
- `ano`, `mes`, `dia`, `horas`, `minutos`, `segundos`, `ht`, `mt`, `st` in 8 each: BCD write data.
- `anole`, `mesle`, `diale`, `horasle`, `minutosle`, `segundosle`, `htle`, `mtle`, `stle` out 8 each: registered read-back data.
- `Listo_es` out 1: write sequence done; level output.
- `Listo_rd` out 1: read sequence done; level output.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `cs_n`, `rd_n`, `wr_n` out 1 each: RTC strobes, active-low.
- `a_d` out 1: 0 selects an address phase, 1 selects a data phase.
- `ad_out` out 8: bus drive value.
- `ad_oe` out 1: bus drive enable; the tristate buffer lives at top level.
- `ad_in` in 8: bus sample input.

## Operation
- **Register table**, index 0..8: segundos 0x21, minutos 0x22, horas 0x23, dia 0x24, mes 0x25, ano 0x26, st 0x41, mt 0x42, ht 0x43.
- **Write sequence** (10 transactions):
  - The nine inputs are snapshotted at the start edge; later changes are ignored.
  - Indices 0..8 are written in table order.
  - A final commit transaction writes 0x00 to address 0xF1.
- **Read sequence** (10 transactions):
  - A latch transaction first writes 0x00 to address 0xF0.
  - Indices 0..8 are then read in table order.
  - Each read updates its `*le` register; all other `*le` registers hold their values.
- **Transaction FSM**: IDLE → A_SET → A_STB → A_HLD → GAP → D_SET → D_STB → D_HLD → D_END → NEXT.
  - Every state except IDLE and NEXT lasts exactly T_PHASE cycles.
  - NEXT lasts 1 cycle and either advances the transaction counter or returns to IDLE after transaction 9.
- **Per-state outputs**:
  - A_SET: `cs_n`=0, `a_d`=0, `ad_oe`=1, `ad_out`=address.
  - A_STB: as A_SET plus `wr_n`=0.
  - A_HLD: `wr_n`=1, address still driven.
  - GAP: `cs_n`=1, `ad_oe`=0.
  - D_SET: `cs_n`=0, `a_d`=1. For writes, `ad_oe`=1 and `ad_out`=data; for reads, `ad_oe`=0.
  - D_STB: `wr_n`=0 for writes, `rd_n`=0 for reads.
  - D_HLD: strobes high.
  - D_END: `cs_n`=1, `ad_oe`=0.
- **Read capture**: `ad_in` is registered into the target `*le` on the last cycle of D_STB.
- **Start arbitration** (IDLE only):
  - If `start_wr` and `start_rd` are both high, write wins and the read is dropped.
  - Starts asserted while `busy` are ignored and not queued.
- **Done flags**:
  - The flag for the finished sequence type is set on the edge that re-enters IDLE.
  - Both flags are cleared on any accepted start.

## Timing
- **Reset values** (applied on the first edge with `reset`=0):
  - `cs_n`=`rd_n`=`wr_n`=1, `a_d`=1, `ad_oe`=0, `ad_out`=0x00.
  - All `*le`=0x00.
  - `Listo_es`=`Listo_rd`=0, `busy`=0.
  - FSM in IDLE, transaction counter 0.
- **Reset mid-sequence**: abort immediately with the reset values above. No completion flag and no partial commit beyond bus edges already issued.
- **Start edge**: start sampled high at edge E0 → A_SET entered at E0, so `cs_n`=0 and `busy`=1 in the cycle after E0.
- **Transaction length**: 8·T_PHASE+1 cycles.
- **Sequence length**: 10·(8·T_PHASE+1) cycles; IDLE and the done flag land at edge E0+10·(8·T_PHASE+1).
  - T_PHASE=10: 810 cycles.
  - T_PHASE=1: 90 cycles.
- **Bus discipline**:
  - `ad_oe` is never 1 while `rd_n`=0.
  - `wr_n` and `rd_n` are never low together.
  - Strobes only fall while `cs_n`=0.
- **Phase counter**: 8-bit, reloads to 0 on each state change, exits a state at count T_PHASE-1.

## Test plan
- **Full write, T_PHASE=2**: load ano=0x16, mes=0x05, dia=0x23, horas=0x14, minutos=0x30, segundos=0x45, ht=0x00, mt=0x01, st=0x30; pulse `start_wr`.
  - Bus monitor sees address/data pairs (0x21,0x45), (0x22,0x30), (0x23,0x14), (0x24,0x23), (0x25,0x05), (0x26,0x16), (0x41,0x30), (0x42,0x01), (0x43,0x00), (0xF1,0x00).
  - `Listo_es`=1 exactly 170 cycles after the start edge.
- **Full read**: RTC model returns 0x59 on address 0x21 and an incrementing pattern elsewhere; pulse `start_rd`.
  - Transaction (0xF0,0x00) is issued first.
  - `segundosle`=0x59 and the other `*le` registers match the model.
  - `Listo_rd`=1 and `Listo_es`=0.
- **Simultaneous starts**: `start_wr` and `start_rd` high in the same IDLE cycle → a write sequence runs and no read occurs. A `start_rd` pulse during `busy` is ignored, and the FSM returns to IDLE with only `Listo_es`=1.
- **Snapshot**: change `ano` to 0x99 mid-sequence → the bus still writes the value present at the start edge to address 0x26.
- **Reset mid-read**: `reset`=0 during D_STB of index 4 → next edge shows `cs_n`=`rd_n`=1, `ad_oe`=0, all `*le`=0x00 and both flags 0; a new `start_rd` then completes normally.
- **Protocol checker** (all runs, T_PHASE=1 and 10): strobe widths equal T_PHASE, no bus contention, and `cs_n` high for T_PHASE cycles in GAP between address and data phases.

Source files
------------

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: multiplexed address/data bus and strobes of the V3023 RTC
interface rtc_bus_ctrl_if;
  logic cs_n, rd_n, wr_n, a_d, ad_oe;
  logic [7:0] ad_out, ad_in;
  modport master (output cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, input ad_in);
  modport slave (input cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, output ad_in);
endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences the nine time/timer registers to and from the V3023 RTC bus
module rtc_bus_ctrl #(
  parameter int T_PHASE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_wr,
  input  logic start_rd,
  input  logic [7:0] ano, mes, dia, horas, minutos, segundos, ht, mt, st,
  output logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle,
  output logic Listo_es,
  output logic Listo_rd,
  output logic busy,
  rtc_bus_ctrl_if.master bus
);
  typedef enum logic [3:0] {IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD, D_END, NEXT} state_t;
  state_t state, state_nx;
  logic [7:0] ph, addr, data;
  logic [3:0] idx, tab;
  logic is_rd, go, last, rd_x, a_ph, d_ph, wr_d;
  logic [7:0] wdat [9];
  logic [7:0] le [9];
  function automatic logic [7:0] reg_addr(input logic [3:0] i);
    return i < 4'd6 ? 8'h21 + {4'd0, i} : 8'h3b + {4'd0, i};
  endfunction
  always_comb begin
    last = ph == 8'(T_PHASE - 1);
    go = state == IDLE && (start_wr || start_rd);
    tab = is_rd ? idx - 4'd1 : idx;
    rd_x = is_rd && idx != 4'd0;
    addr = is_rd ? (idx == 4'd0 ? 8'hf0 : reg_addr(tab)) : (idx == 4'd9 ? 8'hf1 : reg_addr(tab));
    data = is_rd || idx == 4'd9 ? 8'h00 : wdat[tab];
    state_nx = state == IDLE ? (go ? A_SET : IDLE) :
               state == NEXT ? (idx == 4'd9 ? IDLE : A_SET) :
               last ? state_t'(state + 4'd1) : state;
    a_ph = state inside {A_SET, A_STB, A_HLD};
    d_ph = state inside {D_SET, D_STB, D_HLD};
    wr_d = d_ph && !rd_x;
    bus.cs_n = !(a_ph || d_ph);
    bus.a_d = !a_ph;
    bus.wr_n = !(state == A_STB || (state == D_STB && !rd_x));
    bus.rd_n = !(state == D_STB && rd_x);
    bus.ad_oe = a_ph || wr_d;
    bus.ad_out = a_ph ? addr : wr_d ? data : 8'h00;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ph <= '0;
      idx <= '0;
      is_rd <= 1'b0;
      Listo_es <= 1'b0;
      Listo_rd <= 1'b0;
      wdat <= '{default: 8'h00};
      le <= '{default: 8'h00};
    end else begin
      state <= state_nx;
      ph <= state_nx != state || state == IDLE ? 8'd0 : ph + 8'd1;
      if (go) begin
        idx <= '0;
        is_rd <= !start_wr;
        Listo_es <= 1'b0;
        Listo_rd <= 1'b0;
        if (start_wr) wdat <= '{segundos, minutos, horas, dia, mes, ano, st, mt, ht};
      end
      if (state == NEXT) begin
        idx <= idx == 4'd9 ? 4'd0 : idx + 4'd1;
        if (idx == 4'd9) begin
          Listo_es <= !is_rd;
          Listo_rd <= is_rd;
        end
      end
      if (state == D_STB && last && rd_x) le[tab] <= bus.ad_in;
    end
  end
  assign {segundosle, minutosle, horasle, diale, mesle, anole, stle, mtle, htle} =
         {le[0], le[1], le[2], le[3], le[4], le[5], le[6], le[7], le[8]};
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed sequences against a transaction-level model of the RTC controller
module tb_rtc_bus_ctrl;
  localparam int TP = 2;
  logic clk = 0, reset = 0, start_wr = 0, start_rd = 0;
  logic [7:0] ano = 0, mes = 0, dia = 0, horas = 0, minutos = 0, segundos = 0, ht = 0, mt = 0, st = 0;
  logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
  logic listo_es, listo_rd, busy;
  logic [7:0] la = 8'h00;
  rtc_bus_ctrl_if bus();
  always #5 clk = ~clk;
  function automatic logic [7:0] rtc_val(input logic [7:0] a);
    return a == 8'h21 ? 8'h59 : a + 8'h10;
  endfunction
  always @(posedge clk) if (!bus.wr_n && !bus.a_d) la <= bus.ad_out;
  assign bus.ad_in = rtc_val(la);
  rtc_bus_ctrl #(.T_PHASE(TP)) dut (
    .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
    .ano(ano), .mes(mes), .dia(dia), .horas(horas), .minutos(minutos), .segundos(segundos),
    .ht(ht), .mt(mt), .st(st),
    .anole(anole), .mesle(mesle), .diale(diale), .horasle(horasle), .minutosle(minutosle),
    .segundosle(segundosle), .htle(htle), .mtle(mtle), .stle(stle),
    .Listo_es(listo_es), .Listo_rd(listo_rd), .busy(busy), .bus(bus)
  );
  logic [1:0] x_cs, x_rd, x_wr, x_ad, x_oe, x_busy;
  for (genvar g = 0; g < 2; g++) begin : xg
    rtc_bus_ctrl_if xb();
    logic [7:0] xla = 8'h00;
    logic [7:0] le [9];
    logic es, rd;
    always @(posedge clk) if (!xb.wr_n && !xb.a_d) xla <= xb.ad_out;
    assign xb.ad_in = rtc_val(xla);
    rtc_bus_ctrl #(.T_PHASE(g == 0 ? 1 : 10)) x (
      .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
      .ano(ano), .mes(mes), .dia(dia), .horas(horas), .minutos(minutos), .segundos(segundos),
      .ht(ht), .mt(mt), .st(st),
      .anole(le[5]), .mesle(le[4]), .diale(le[3]), .horasle(le[2]), .minutosle(le[1]),
      .segundosle(le[0]), .htle(le[8]), .mtle(le[7]), .stle(le[6]),
      .Listo_es(es), .Listo_rd(rd), .busy(x_busy[g]), .bus(xb)
    );
    assign x_cs[g] = xb.cs_n;
    assign x_rd[g] = xb.rd_n;
    assign x_wr[g] = xb.wr_n;
    assign x_ad[g] = xb.a_d;
    assign x_oe[g] = xb.ad_oe;
  end
  int errors = 0, checks = 0, cyc = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask
  logic [7:0] tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  // transactions are {is_read, address, data}
  logic [16:0] expq [$];
  logic [16:0] log [$];
  int m_left = 0;
  logic m_es = 0, m_rd = 0, m_isrd = 0;
  logic [7:0] m_le [9] = '{default: 8'h00};
  logic [7:0] wv [9];
  logic [7:0] les [9];
  logic [7:0] cur = 8'h00;
  logic rp = 0;
  int tps [3] = '{TP, 1, 10};
  int wl [3], rl [3], ch [3], t0 [3];
  logic pw [3], pr [3], pc [3], arm [3], lad [3], pb [3];
  task automatic got(input logic [16:0] t);
    log.push_back(t);
    chk("txn_pending", expq.size() > 0, 1);
    if (expq.size() > 0) chk("txn", t, expq.pop_front());
  endtask
  task automatic prot(input int k, input logic cs, rd, wr, ad, oe, bz);
    int t = tps[k];
    if (!rp) begin
      wl[k] = 0; rl[k] = 0; ch[k] = 0; t0[k] = -1;
      pw[k] = 1; pr[k] = 1; pc[k] = 1; arm[k] = 0; lad[k] = 1; pb[k] = 0;
      return;
    end
    chk("oe_while_rd", oe && !rd, 0);
    chk("wr_rd_overlap", !wr && !rd, 0);
    if (pw[k] && !wr) chk("wr_fall_cs", cs, 0);
    if (pr[k] && !rd) chk("rd_fall_cs", cs, 0);
    if (!wr) wl[k]++;
    if (!pw[k] && wr) begin chk("wr_width", wl[k], t); wl[k] = 0; end
    if (!rd) rl[k]++;
    if (!pr[k] && rd) begin chk("rd_width", rl[k], t); rl[k] = 0; end
    if (!pc[k] && cs) begin arm[k] = !lad[k]; ch[k] = 0; end
    if (cs) ch[k]++;
    if (pc[k] && !cs) begin
      if (arm[k]) chk("gap_cs_high", ch[k], t);
      arm[k] = 0;
    end
    if (!cs) lad[k] = ad;
    if (!pb[k] && bz) t0[k] = cyc;
    if (pb[k] && !bz && t0[k] >= 0) chk("seq_len", cyc - t0[k], 10 * (8 * t + 1));
    pw[k] = wr; pr[k] = rd; pc[k] = cs; pb[k] = bz;
  endtask
  initial forever begin
    @(negedge clk);
    cyc++;
    chk("busy", busy, m_left != 0);
    chk("listo_es", listo_es, m_es);
    chk("listo_rd", listo_rd, m_rd);
    if (m_left == 0) begin
      les = '{segundosle, minutosle, horasle, diale, mesle, anole, stle, mtle, htle};
      for (int i = 0; i < 9; i++) chk("le", les[i], m_le[i]);
      chk("idle_cs_n", bus.cs_n, 1);
      chk("idle_ad_oe", bus.ad_oe, 0);
    end
    if (rp && pw[0] && !bus.wr_n) begin
      if (!bus.a_d) cur = bus.ad_out;
      else got({1'b0, cur, bus.ad_out});
    end
    if (rp && pr[0] && !bus.rd_n) got({1'b1, cur, 8'h00});
    prot(0, bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, busy);
    prot(1, x_cs[0], x_rd[0], x_wr[0], x_ad[0], x_oe[0], x_busy[0]);
    prot(2, x_cs[1], x_rd[1], x_wr[1], x_ad[1], x_oe[1], x_busy[1]);
    if (!reset) begin
      m_left = 0; m_es = 0; m_rd = 0; m_le = '{default: 8'h00}; expq.delete();
    end else if (m_left == 0) begin
      if (start_wr || start_rd) begin
        m_left = 10 * (8 * TP + 1); m_isrd = !start_wr; m_es = 0; m_rd = 0;
        if (start_wr) begin
          wv = '{segundos, minutos, horas, dia, mes, ano, st, mt, ht};
          for (int i = 0; i < 9; i++) expq.push_back({1'b0, tbl[i], wv[i]});
          expq.push_back({1'b0, 8'hf1, 8'h00});
        end else begin
          expq.push_back({1'b0, 8'hf0, 8'h00});
          for (int i = 0; i < 9; i++) expq.push_back({1'b1, tbl[i], 8'h00});
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        chk("txn_left", expq.size(), 0);
        m_es = !m_isrd; m_rd = m_isrd;
        if (m_isrd) for (int i = 0; i < 9; i++) m_le[i] = rtc_val(tbl[i]);
      end
    end
    rp = reset;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_idle(input string nm, input bit all);
    int n = 0;
    while ((busy || (all && x_busy != 2'b00)) && n < 2000) begin tick(); n++; end
    chk({nm, "_timeout"}, n < 2000, 1);
  endtask
  function automatic int nreads();
    int c = 0;
    foreach (log[i]) if (log[i][16]) c++;
    return c;
  endfunction
  logic [16:0] exp_wr [10] = '{17'h02145, 17'h02230, 17'h02314, 17'h02423, 17'h02505,
                               17'h02616, 17'h04130, 17'h04201, 17'h04300, 17'h0f100};
  initial begin
    int n;
    tick(3);
    chk("rst_cs_n", bus.cs_n, 1); chk("rst_rd_n", bus.rd_n, 1); chk("rst_wr_n", bus.wr_n, 1);
    chk("rst_a_d", bus.a_d, 1); chk("rst_ad_oe", bus.ad_oe, 0); chk("rst_ad_out", bus.ad_out, 0);
    chk("rst_busy", busy, 0); chk("rst_anole", anole, 0);
    reset = 1;
    tick();
    ano = 8'h16; mes = 8'h05; dia = 8'h23; horas = 8'h14; minutos = 8'h30; segundos = 8'h45;
    ht = 8'h00; mt = 8'h01; st = 8'h30;
    log.delete();
    start_wr = 1; tick(); start_wr = 0;
    chk("wr_busy_after_start", busy, 1);
    n = 0;
    while (!listo_es && n < 1000) begin tick(); n++; end
    chk("wr_done_cycles", n, 170);
    chk("wr_count", log.size(), 10);
    for (int i = 0; i < 10; i++) if (i < log.size()) chk("wr_pair", log[i], exp_wr[i]);
    log.delete();
    start_rd = 1; tick(); start_rd = 0;
    wait_idle("rd", 0);
    chk("rd_count", log.size(), 10);
    if (log.size() > 0) chk("rd_latch", log[0], 17'h0f000);
    chk("rd_segundosle", segundosle, 8'h59); chk("rd_minutosle", minutosle, 8'h32);
    chk("rd_horasle", horasle, 8'h33); chk("rd_stle", stle, 8'h51); chk("rd_htle", htle, 8'h53);
    chk("rd_listo_rd", listo_rd, 1); chk("rd_listo_es", listo_es, 0);
    log.delete();
    start_wr = 1; start_rd = 1; tick(); start_wr = 0; start_rd = 0;
    tick(20);
    start_rd = 1; tick(); start_rd = 0;
    wait_idle("sim", 0);
    tick(5);
    chk("sim_reads", nreads(), 0); chk("sim_count", log.size(), 10);
    chk("sim_listo_es", listo_es, 1); chk("sim_listo_rd", listo_rd, 0); chk("sim_idle", busy, 0);
    log.delete();
    start_wr = 1; tick(); start_wr = 0;
    tick(10);
    ano = 8'h99;
    wait_idle("snap", 0);
    if (log.size() > 5) chk("snap_ano", log[5], 17'h02616);
    log.delete();
    start_rd = 1; tick(); start_rd = 0;
    n = 0;
    while (nreads() < 5 && n < 1000) begin tick(); n++; end
    chk("rst_mid_reached", n < 1000, 1);
    chk("rd_n_before_reset", bus.rd_n, 0);
    reset = 0; tick();
    chk("mid_cs_n", bus.cs_n, 1); chk("mid_rd_n", bus.rd_n, 1); chk("mid_ad_oe", bus.ad_oe, 0);
    chk("mid_segundosle", segundosle, 0); chk("mid_anole", anole, 0);
    chk("mid_listo_es", listo_es, 0); chk("mid_listo_rd", listo_rd, 0); chk("mid_busy", busy, 0);
    tick(); reset = 1; tick();
    start_rd = 1; tick(); start_rd = 0;
    wait_idle("rd2", 0);
    chk("rd2_segundosle", segundosle, 8'h59); chk("rd2_listo_rd", listo_rd, 1);
    wait_idle("drain", 1);
    log.delete();
    start_wr = 1; tick(); start_wr = 0;
    wait_idle("final", 1);
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
